// File: rtl/mpa_pkg.sv
// Shared definitions for multi_port_adapter: register map,
// flag/control bit positions and timer state encoding.
package mpa_pkg;

  localparam logic [3:0] REG_IFR  = 4'd8;
  localparam logic [3:0] REG_IER  = 4'd9;
  localparam logic [3:0] REG_TLL  = 4'd10;
  localparam logic [3:0] REG_TLH  = 4'd11;
  localparam logic [3:0] REG_TCL  = 4'd12;
  localparam logic [3:0] REG_TCH  = 4'd13;
  localparam logic [3:0] REG_CTRL = 4'd14;

  localparam int IFR_TMR   = 6;
  localparam int IFR_IRQ   = 7;
  localparam int IER_SET   = 7;
  localparam int CTRL_FREE = 4;

  typedef enum logic {
    IDLE,
    RUN
  } tmr_state_e;

endpackage

// File: rtl/mpa_timer.sv
// 16-bit interval timer: latch, down-counter, one-shot/free-run
// mode and a single-cycle expiry indication.
module mpa_timer
  import mpa_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic        free_run_i,
  input  logic [7:0]  data_i,
  output logic [15:0] latch_o,
  output logic [15:0] count_o,
  output logic        expire_o
);

  tmr_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  lat_lo_q, lat_hi_q;

  assign latch_o  = {lat_hi_q, lat_lo_q};
  assign count_o  = cnt_q;
  assign expire_o = (state_q == RUN) && (cnt_q == 16'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: ;
      RUN: begin
        if (cnt_q == 16'd0) begin
          if (free_run_i) cnt_d = latch_o;
          else            state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
    endcase
    // a high-byte load overrides any expiry in the same cycle
    if (wr_hi_i) begin
      state_d = RUN;
      cnt_d   = {data_i, lat_lo_q};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lat_lo_q <= '0;
      lat_hi_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (wr_lo_i) lat_lo_q <= data_i;
      if (wr_hi_i) lat_hi_q <= data_i;
    end
  end

endmodule

// File: rtl/multi_port_adapter.sv
// Multi-port GPIO adapter with edge interrupts and an optional
// interval timer enabled by defining MPA_TIMER_EN.
module multi_port_adapter
  import mpa_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   chip_en,
  input  logic                   write_en,
  input  logic [3:0]             register_select,
  input  logic [7:0]             data_in,
  output logic [7:0]             data_out,
  input  logic [8*NUM_PORTS-1:0] port_in,
  output logic [8*NUM_PORTS-1:0] port_out,
  output logic [8*NUM_PORTS-1:0] port_oe,
  input  logic [NUM_PORTS-1:0]   ctl_in,
  output logic                   irq
);

  localparam int PW = 8 * NUM_PORTS;
  localparam logic [6:0] PORT_MASK =
    7'((1 << NUM_PORTS) - 1);

`ifdef MPA_TIMER_EN
  localparam logic [6:0] TMR_MASK  = 7'h40;
  localparam logic [4:0] CTRL_MASK = 5'h1F;
`else
  localparam logic [6:0] TMR_MASK  = 7'h00;
  localparam logic [4:0] CTRL_MASK = 5'h0F;
`endif
  localparam logic [6:0] IFR_MASK = PORT_MASK | TMR_MASK;

  logic [PW-1:0]        or_q, or_d, ddr_q, ddr_d;
  logic [6:0]           ifr_q, ifr_d, ier_q, ier_d;
  logic [4:0]           ctrl_q, ctrl_d;
  logic [NUM_PORTS-1:0] cprev_q, ctl_hit;
  logic [PW-1:0]        ps;
  logic [NUM_PORTS-1:0] cs;
  logic [6:0]           ifr_set, ifr_clr;
  logic [7:0]           port_rd;
  logic [15:0]          tmr_latch, tmr_count;
  logic                 tmr_expire;
  logic                 wr, rd, wr_tlh, rd_tcl;

  for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync
    logic [PW-1:0]        p_q, p_d;
    logic [NUM_PORTS-1:0] c_q, c_d;
    if (s == 0) begin : g_in
      assign p_d = port_in;
      assign c_d = ctl_in;
    end else begin : g_chain
      assign p_d = g_sync[s-1].p_q;
      assign c_d = g_sync[s-1].c_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        p_q <= '0;
        c_q <= '0;
      end else begin
        p_q <= p_d;
        c_q <= c_d;
      end
    end
  end

  assign ps = g_sync[SYNC_STAGES-1].p_q;
  assign cs = g_sync[SYNC_STAGES-1].c_q;

  assign wr     = chip_en & write_en;
  assign rd     = chip_en & ~write_en;
  assign wr_tlh = wr && (register_select == REG_TLH);
  assign rd_tcl = rd && (register_select == REG_TCL);

`ifdef MPA_TIMER_EN
  logic wr_tll;
  assign wr_tll = wr && (register_select == REG_TLL);

  mpa_timer u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_lo_i    (wr_tll),
    .wr_hi_i    (wr_tlh),
    .free_run_i (ctrl_q[CTRL_FREE]),
    .data_i     (data_in),
    .latch_o    (tmr_latch),
    .count_o    (tmr_count),
    .expire_o   (tmr_expire)
  );
`else
  assign tmr_latch  = '0;
  assign tmr_count  = '0;
  assign tmr_expire = 1'b0;
`endif

  // polarity only selects the compare; prev sample always tracks
  assign ctl_hit =
    ( cs & ~cprev_q &  ctrl_q[NUM_PORTS-1:0]) |
    (~cs &  cprev_q & ~ctrl_q[NUM_PORTS-1:0]);

  always_comb begin
    or_d   = or_q;
    ddr_d  = ddr_q;
    ier_d  = ier_q;
    ctrl_d = ctrl_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (wr && !register_select[3] &&
          register_select[2:1] == 2'(p)) begin
        if (register_select[0]) ddr_d[8*p +: 8] = data_in;
        else                    or_d[8*p +: 8]  = data_in;
      end
    end
    if (wr && register_select == REG_IER) begin
      if (data_in[IER_SET]) ier_d = ier_q | data_in[6:0];
      else                  ier_d = ier_q & ~data_in[6:0];
      ier_d = ier_d & IFR_MASK;
    end
    if (wr && register_select == REG_CTRL)
      ctrl_d = data_in[4:0] & CTRL_MASK;
  end

  // sets win over clears; a timer load suppresses its own expiry
  always_comb begin
    ifr_set = {tmr_expire & ~wr_tlh, 6'b0} | 7'(ctl_hit);
    ifr_clr = {wr_tlh | rd_tcl, 6'b0};
    if (wr && register_select == REG_IFR)
      ifr_clr = ifr_clr | data_in[6:0];
    ifr_d = ((ifr_q & ~ifr_clr) | ifr_set) & IFR_MASK;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      or_q    <= '0;
      ddr_q   <= '0;
      ifr_q   <= '0;
      ier_q   <= '0;
      ctrl_q  <= '0;
      cprev_q <= '0;
    end else begin
      or_q    <= or_d;
      ddr_q   <= ddr_d;
      ifr_q   <= ifr_d;
      ier_q   <= ier_d;
      ctrl_q  <= ctrl_d;
      cprev_q <= cs;
    end
  end

  assign port_out = or_q;
  assign port_oe  = ddr_q;
  assign irq      = |(ifr_q & ier_q);

  always_comb begin
    port_rd = 8'h00;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (register_select[2:1] == 2'(p)) begin
        if (register_select[0])
          port_rd = ddr_q[8*p +: 8];
        else
          port_rd = (or_q[8*p +: 8] & ddr_q[8*p +: 8]) |
                    (ps[8*p +: 8] & ~ddr_q[8*p +: 8]);
      end
    end
    data_out = 8'h00;
    if (chip_en) begin
      unique case (1'b1)
        !register_select[3]:
          data_out = port_rd;
        register_select == REG_IFR:
          data_out = {irq, ifr_q};
        register_select == REG_IER:
          data_out = {1'b1, ier_q};
        register_select == REG_TLL:
          data_out = tmr_latch[7:0];
        register_select == REG_TLH:
          data_out = tmr_latch[15:8];
        register_select == REG_TCL:
          data_out = tmr_count[7:0];
        register_select == REG_TCH:
          data_out = tmr_count[15:8];
        register_select == REG_CTRL:
          data_out = {3'b000, ctrl_q};
        default:
          data_out = 8'h00;
      endcase
    end
  end

endmodule
